alu_result_fifo: RTL and testbench



---
 rtl/alu_result_fifo.sv | 97 +++++++++
 tb/tb_alu_result_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: show-ahead FIFO capturing ALU results/flags/opcode, with saturating zero/negative statistics.
//   Ports: clk, rst_n (async active-low); push side in_valid_i/in_ready_o with in_data_i, in_zer_i, in_neg_i, in_opc_i;
//   pop side out_valid_o/out_ready_i with out_data_o, out_zer_o, out_neg_o, out_opc_o; count_o occupancy;
//   clr_cnt_i clears zero_cnt_o/neg_cnt_o; flag_err_o sticky flag-consistency error.
//   Macro ALU_FLAG_CHECK_EN enables the flag checker; otherwise flag_err_o is tied low.
module alu_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_data_i,
    input  logic                       in_zer_i,
    input  logic                       in_neg_i,
    input  logic [2:0]                 in_opc_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_data_o,
    output logic                       out_zer_o,
    output logic                       out_neg_o,
    output logic [2:0]                 out_opc_o,
    output logic [$clog2(DEPTH):0]     count_o,
    input  logic                       clr_cnt_i,
    output logic [CNT_W-1:0]           zero_cnt_o,
    output logic [CNT_W-1:0]           neg_cnt_o,
    output logic                       flag_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + 5;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d, head_idx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] zero_q, zero_d, neg_q, neg_d;
    logic             push, pop;

    assign in_ready_o  = cnt_q != CW'(DEPTH);
    assign out_valid_o = cnt_q != '0;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign count_o     = cnt_q;
    assign zero_cnt_o  = zero_q;
    assign neg_cnt_o   = neg_q;

    // When empty, the slot just behind the read pointer is the last entry read;
    // it cannot be overwritten until a push makes the FIFO non-empty again.
    assign head_idx = out_valid_o ? rd_q : rd_q - 1'b1;
    assign {out_opc_o, out_zer_o, out_neg_o, out_data_o} = mem_q[head_idx];

    always_comb begin
        wr_d   = push ? wr_q + 1'b1 : wr_q;
        rd_d   = pop ? rd_q + 1'b1 : rd_q;
        cnt_d  = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
        zero_d = clr_cnt_i ? '0 : (push && in_zer_i && !(&zero_q)) ? zero_q + 1'b1 : zero_q;
        neg_d  = clr_cnt_i ? '0 : (push && in_neg_i && !(&neg_q)) ? neg_q + 1'b1 : neg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            zero_q <= '0;
            neg_q  <= '0;
        end else begin
            if (push) mem_q[wr_q] <= {in_opc_i, in_zer_i, in_neg_i, in_data_i};
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

`ifdef ALU_FLAG_CHECK_EN
    logic flag_q, flag_d;

    // Sticky: only reset clears it, clr_cnt_i deliberately does not.
    always_comb begin
        flag_d = flag_q | (push & ((in_zer_i != (in_data_i == '0)) | (in_neg_i != in_data_i[WIDTH-1])));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flag_q <= 1'b0;
        else flag_q <= flag_d;
    end

    assign flag_err_o = flag_q;
`else
    assign flag_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: scoreboard bench for alu_result_fifo with directed vectors.
module tb_alu_result_fifo;
`ifdef ALU_FLAG_CHECK_EN
    localparam logic EXP_FE = 1'b1;
`else
    localparam logic EXP_FE = 1'b0;
`endif

    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready, in_zer = 0, in_neg = 0;
    logic [15:0] in_data = 0, out_data;
    logic [2:0]  in_opc = 0, out_opc;
    logic        out_valid, out_ready = 0, out_zer, out_neg, clr_cnt = 0, flag_err;
    logic [2:0]  count;
    logic [7:0]  zero_cnt, neg_cnt;

    int vectors = 0, miscompares = 0;
    logic [20:0] sb[$];

    alu_result_fifo #(.WIDTH(16), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .in_zer_i(in_zer), .in_neg_i(in_neg), .in_opc_i(in_opc),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_zer_o(out_zer), .out_neg_o(out_neg), .out_opc_o(out_opc),
        .count_o(count), .clr_cnt_i(clr_cnt), .zero_cnt_o(zero_cnt),
        .neg_cnt_o(neg_cnt), .flag_err_o(flag_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until accepted (bounded); in_valid is left high for back-to-back pushes.
    task automatic push(input logic [15:0] d, input logic z, input logic n, input logic [2:0] o);
        logic acc;
        int k;
        in_valid = 1; in_data = d; in_zer = z; in_neg = n; in_opc = o;
        k = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            k++;
        end while (!acc && k < 20);
        if (acc) sb.push_back({o, z, n, d});
        else begin
            check("push_timeout", 0, 1);
            in_valid = 0;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) tick();
    endtask

    // Monitor: occupancy tracks the scoreboard, and every handshaken head matches its front.
    always @(negedge clk) begin
        if (rst_n) begin
            check("occupancy", 32'(count), 32'(sb.size()));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("unexpected_out", 1, 0);
                else check("head_entry", {11'b0, out_opc, out_zer, out_neg, out_data}, {11'b0, sb.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_zero_cnt", 32'(zero_cnt), 0);
        check("rst_neg_cnt", 32'(neg_cnt), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_flag_err", 32'(flag_err), 0);
        idle(2);
        // two entries, consumer stalled
        push(16'h0005, 0, 0, 3'd2);
        push(16'hFFF0, 0, 1, 3'd5);
        idle(1);
        check("stall_count", 32'(count), 2);
        check("stall_head", 32'(out_data), 32'h0005);
        out_ready = 1;
        tick(); tick();
        out_ready = 0;
        check("neg_cnt_1", 32'(neg_cnt), 1);
        check("zero_cnt_0", 32'(zero_cnt), 0);
        // fill, stall the 5th, wrap pointers
        push(16'h0011, 0, 0, 3'd1);
        push(16'h0022, 0, 0, 3'd2);
        push(16'h0033, 0, 0, 3'd3);
        push(16'h0044, 0, 0, 3'd4);
        in_valid = 1; in_data = 16'h0055; in_opc = 3'd6;
        tick(); tick();
        check("full_in_ready", 32'(in_ready), 0);
        check("full_count", 32'(count), 4);
        in_valid = 0; out_ready = 1;
        tick();
        out_ready = 0;
        check("after_pop_count", 32'(count), 3);
        push(16'h0055, 0, 0, 3'd6);
        in_valid = 0;
        check("refill_count", 32'(count), 4);
        out_ready = 1;
        tick();
        push(16'h0066, 0, 0, 3'd7);
        in_valid = 0; out_ready = 0;
        check("push_pop_count", 32'(count), 3);
        out_ready = 1;
        idle(5);
        check("drained_valid", 32'(out_valid), 0);
        // zero counter saturation with streaming push/pop
        for (int i = 0; i < 255; i++) push(16'h0000, 1, 0, 3'(i));
        check("zero_cnt_255", 32'(zero_cnt), 255);
        for (int i = 0; i < 45; i++) push(16'h0000, 1, 0, 3'(i));
        check("zero_cnt_sat", 32'(zero_cnt), 255);
        check("neg_cnt_hold", 32'(neg_cnt), 1);
        check("flag_clean", 32'(flag_err), 0);
        clr_cnt = 1;
        push(16'h0000, 1, 0, 3'd1);
        clr_cnt = 0;
        check("clr_zero", 32'(zero_cnt), 0);
        check("clr_neg", 32'(neg_cnt), 0);
        push(16'h8001, 0, 1, 3'd2);
        in_valid = 0;
        check("neg_after_clr", 32'(neg_cnt), 1);
        // inconsistent flags: 0x0000 with zer=0
        push(16'h0000, 0, 0, 3'd4);
        in_valid = 0;
        check("flag_err_set", 32'(flag_err), 32'(EXP_FE));
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        check("flag_err_sticky", 32'(flag_err), 32'(EXP_FE));
        idle(3);
        // async reset with entries queued
        out_ready = 0;
        push(16'h0101, 0, 0, 3'd1);
        push(16'h0202, 0, 0, 3'd2);
        push(16'h0303, 0, 0, 3'd3);
        in_valid = 0;
        #2 rst_n = 0;
        sb.delete();
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_count", 32'(count), 0);
        check("arst_flag_err", 32'(flag_err), 0);
        check("arst_out_data", 32'(out_data), 0);
        @(posedge clk);
        #1 rst_n = 1;
        push(16'h1234, 0, 0, 3'd7);
        in_valid = 0;
        check("post_rst_head", 32'(out_data), 32'h1234);
        out_ready = 1;
        idle(3);
        check("final_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
